// File: rtl/hs_stream_pkg.sv
// Shared types and defaults for the hs_stream_source host-side kernel driver.
package hs_stream_pkg;

  localparam int unsigned DefDataW = 32;
  localparam int unsigned DefLenW  = 16;

  localparam logic [1:0] IdleEnc = 2'd0;

  typedef enum logic [1:0] {
    StIdle  = IdleEnc,
    StRun   = 2'd1,
    StDrain = 2'd2,
    StFin   = 2'd3
  } state_e;

endpackage

// File: rtl/hs_stream_source_if.sv
// Kernel-facing bundle: ap_ctrl_hs block control plus the value/last ap_hs stream pair.
interface hs_stream_source_if
  import hs_stream_pkg::*;
#(
  parameter int unsigned DATA_W = DefDataW
) ();

  logic              ap_start;
  logic              ap_ready;
  logic              ap_done;
  logic              ap_idle;
  logic [DATA_W-1:0] value_V;
  logic              value_V_ap_vld;
  logic              value_V_ap_ack;
  logic              last_V;
  logic              last_V_ap_vld;
  logic              last_V_ap_ack;

  modport master (
    output ap_start,
    input  ap_ready,
    input  ap_done,
    input  ap_idle,
    output value_V,
    output value_V_ap_vld,
    input  value_V_ap_ack,
    output last_V,
    output last_V_ap_vld,
    input  last_V_ap_ack
  );

  modport slave (
    input  ap_start,
    output ap_ready,
    output ap_done,
    output ap_idle,
    input  value_V,
    input  value_V_ap_vld,
    output value_V_ap_ack,
    input  last_V,
    input  last_V_ap_vld,
    output last_V_ap_ack
  );

endinterface

// File: rtl/hs_chan_tx.sv
// One ap_hs transmit channel: tracks vld and whether the current word was already accepted.
module hs_chan_tx (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic load_i,
  input  logic ack_i,
  input  logic clear_i,
  output logic vld_o,
  output logic acked_o
);

  logic vld_q, vld_d;
  logic acked_q, acked_d;

  // load beats clear so a fresh word can be presented the cycle after completion
  always_comb begin
    vld_d   = vld_q;
    acked_d = acked_q;
    if (load_i) begin
      vld_d   = 1'b1;
      acked_d = 1'b0;
    end else if (clear_i) begin
      vld_d   = 1'b0;
      acked_d = 1'b0;
    end else if (vld_q && ack_i) begin
      vld_d   = 1'b0;
      acked_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_q   <= 1'b0;
      acked_q <= 1'b0;
    end else begin
      vld_q   <= vld_d;
      acked_q <= acked_d;
    end
  end

  assign vld_o   = vld_q;
  assign acked_o = acked_q;

endmodule

// File: rtl/hs_stream_source.sv
// Starts an ap_ctrl_hs kernel, streams base + k*step on value/last ap_hs channels,
// then waits for ap_done and pulses done.
module hs_stream_source
  import hs_stream_pkg::*;
#(
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned LEN_W  = DefLenW
) (
  input  logic               ap_clk,
  input  logic               ap_rst_n,
  input  logic               cfg_start,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic [DATA_W-1:0]  cfg_base,
  input  logic [DATA_W-1:0]  cfg_step,
  output logic               busy,
  output logic               done,
  hs_stream_source_if.master kif
);

  state_e            state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  k_q, k_d;
  logic [DATA_W-1:0] cur_q, cur_d;
  logic [DATA_W-1:0] step_q, step_d;
  logic              ap_start_q, ap_start_d;
  logic              done_seen_q, done_seen_d;
  logic              reload_q, reload_d;

  logic accept, is_last, word_done, chan_load;
  logic v_vld, v_acked, l_vld, l_acked;

  assign accept    = (state_q == StIdle) && cfg_start && (cfg_len != '0) && kif.ap_idle;
  assign is_last   = (k_q == len_q - LEN_W'(1));
  assign word_done = (state_q == StRun)
                   && (v_acked || (v_vld && kif.value_V_ap_ack))
                   && (l_acked || (l_vld && kif.last_V_ap_ack));
  // Reload is delayed a cycle so each channel shows vld=0 between words
  assign chan_load = accept || reload_q;

  hs_chan_tx u_value_tx (
    .clk_i   (ap_clk),
    .rst_ni  (ap_rst_n),
    .load_i  (chan_load),
    .ack_i   (kif.value_V_ap_ack),
    .clear_i (word_done),
    .vld_o   (v_vld),
    .acked_o (v_acked)
  );

  hs_chan_tx u_last_tx (
    .clk_i   (ap_clk),
    .rst_ni  (ap_rst_n),
    .load_i  (chan_load),
    .ack_i   (kif.last_V_ap_ack),
    .clear_i (word_done),
    .vld_o   (l_vld),
    .acked_o (l_acked)
  );

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    k_d         = k_q;
    cur_d       = cur_q;
    step_d      = step_q;
    ap_start_d  = ap_start_q;
    done_seen_d = done_seen_q;
    reload_d    = word_done && !is_last;

    if (ap_start_q && kif.ap_ready) begin
      ap_start_d = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          len_d       = cfg_len;
          step_d      = cfg_step;
          cur_d       = cfg_base;
          k_d         = '0;
          ap_start_d  = 1'b1;
          done_seen_d = 1'b0;
          state_d     = StRun;
        end
      end
      StRun: begin
        if (kif.ap_done) begin
          done_seen_d = 1'b1;
        end
        if (word_done) begin
          cur_d = cur_q + step_q;
          // k stays at len-1 after the final word
          if (is_last) begin
            state_d = StDrain;
          end else begin
            k_d = k_q + LEN_W'(1);
          end
        end
      end
      StDrain: begin
        if (kif.ap_done) begin
          done_seen_d = 1'b1;
        end
        if ((done_seen_q || kif.ap_done) && !ap_start_q) begin
          state_d = StFin;
        end
      end
      StFin: begin
        done_seen_d = 1'b0;
        state_d     = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q     <= StIdle;
      len_q       <= '0;
      k_q         <= '0;
      cur_q       <= '0;
      step_q      <= '0;
      ap_start_q  <= 1'b0;
      done_seen_q <= 1'b0;
      reload_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      k_q         <= k_d;
      cur_q       <= cur_d;
      step_q      <= step_d;
      ap_start_q  <= ap_start_d;
      done_seen_q <= done_seen_d;
      reload_q    <= reload_d;
    end
  end

  assign busy               = (state_q != StIdle);
  assign done               = (state_q == StFin);
  assign kif.ap_start       = ap_start_q;
  assign kif.value_V        = cur_q;
  assign kif.value_V_ap_vld = v_vld;
  assign kif.last_V         = (state_q == StRun) && is_last;
  assign kif.last_V_ap_vld  = l_vld;

endmodule

// File: tb/tb_hs_stream_source.sv
// Directed bench for hs_stream_source: acts as the ap_ctrl_hs kernel and stream sink.
module tb_hs_stream_source;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_start = 1'b0;
  logic [15:0] cfg_len = '0;
  logic [31:0] cfg_base = '0;
  logic [31:0] cfg_step = '0;
  logic        busy;
  logic        done;

  hs_stream_source_if #(.DATA_W(32)) kif ();

  hs_stream_source #(.DATA_W(32), .LEN_W(16)) dut (
    .ap_clk    (clk),
    .ap_rst_n  (rst_n),
    .cfg_start (cfg_start),
    .cfg_len   (cfg_len),
    .cfg_base  (cfg_base),
    .cfg_step  (cfg_step),
    .busy      (busy),
    .done      (done),
    .kif       (kif)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [31:0] got_val [16];
  logic        got_last [16];
  int          nw, ndone, done_iter, start_rises;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_cmd(input logic [15:0] len, input logic [31:0] base,
                           input logic [31:0] step);
    cfg_len   = len;
    cfg_base  = base;
    cfg_step  = step;
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
  endtask

  // Kernel/sink model with acks tied high; records words and done timing (no checks here)
  task automatic run_stream(input int max_iter, input int exp_words, input int early_done_iter,
                            input int poke_iter);
    int   done_sent;
    logic prev_start;
    done_sent   = 0;
    prev_start  = 1'b0;
    nw          = 0;
    ndone       = 0;
    done_iter   = -1;
    start_rises = 0;
    for (int c = 0; c < max_iter; c++) begin
      if (kif.value_V_ap_vld) begin
        if (nw < 16) begin
          got_val[nw]  = kif.value_V;
          got_last[nw] = kif.last_V;
        end
        nw++;
      end
      if (done) begin
        ndone++;
        if (done_iter < 0) done_iter = c;
      end
      if (kif.ap_start && !prev_start) start_rises++;
      prev_start   = kif.ap_start;
      kif.ap_ready = kif.ap_start;
      kif.ap_done  = 1'b0;
      if (done_sent == 0 && ((early_done_iter >= 0) ? (c == early_done_iter)
                                                     : (nw == exp_words))) begin
        kif.ap_done = 1'b1;
        done_sent   = 1;
      end
      cfg_start = (c == poke_iter);
      tick();
      if (done_iter >= 0 && c >= done_iter + 1) break;
    end
    cfg_start    = 1'b0;
    kif.ap_done  = 1'b0;
    kif.ap_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (kif.ap_start !== 1'b0) begin failures++;
      $display("FAIL reset_ap_start got=%b exp=0", kif.ap_start); end
    checks++; if ({kif.value_V_ap_vld, kif.last_V_ap_vld} !== 2'b00) begin failures++;
      $display("FAIL reset_vld got=%b exp=00", {kif.value_V_ap_vld, kif.last_V_ap_vld}); end
    checks++; if (kif.value_V !== 32'd0 || kif.last_V !== 1'b0) begin failures++;
      $display("FAIL reset_data got=%h/%b exp=0/0", kif.value_V, kif.last_V); end
    rst_n = 1'b1;
    tick();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_release_busy got=%b exp=0", busy); end
  endtask

  task automatic test_basic();
    issue_cmd(16'd4, 32'd10, 32'd5);
    checks++; if (busy !== 1'b1 || kif.ap_start !== 1'b1) begin failures++;
      $display("FAIL basic_start got busy=%b ap_start=%b exp=1/1", busy, kif.ap_start); end
    run_stream(30, 4, -1, -1);
    checks++; if (nw !== 4) begin failures++; $display("FAIL basic_words got=%0d exp=4", nw); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (got_val[i] !== 32'(10 + 5 * i)) begin failures++;
        $display("FAIL basic_val%0d got=%0d exp=%0d", i, got_val[i], 10 + 5 * i); end
      checks++; if (got_last[i] !== (i == 3)) begin failures++;
        $display("FAIL basic_last%0d got=%b exp=%b", i, got_last[i], (i == 3)); end
    end
    checks++; if (ndone !== 1) begin failures++; $display("FAIL basic_ndone got=%0d exp=1", ndone); end
    checks++; if (done_iter !== 8) begin failures++;
      $display("FAIL basic_done_time got=%0d exp=8", done_iter); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL basic_busy_after got=%b exp=0", busy); end
  endtask

  task automatic test_skewed_acks();
    int lcnt, nl, err_val, err_vvld, ndn, dsent;
    lcnt = 0; nl = 0; err_val = 0; err_vvld = 0; ndn = 0; dsent = 0;
    kif.value_V_ap_ack = 1'b1;
    kif.last_V_ap_ack  = 1'b0;
    issue_cmd(16'd3, 32'd100, 32'd7);
    for (int c = 0; c < 60; c++) begin
      if (kif.last_V_ap_vld) lcnt++;
      else lcnt = 0;
      if (kif.last_V_ap_vld) begin
        if (kif.value_V !== 32'(100 + 7 * nl) || kif.last_V !== (nl == 2)) err_val++;
        if (lcnt == 1 && kif.value_V_ap_vld !== 1'b1) err_vvld++;
        if (lcnt >= 2 && kif.value_V_ap_vld !== 1'b0) err_vvld++;
      end
      kif.last_V_ap_ack = (lcnt == 4);
      if (lcnt == 4) nl++;
      if (done) ndn++;
      kif.ap_ready = kif.ap_start;
      kif.ap_done  = 1'b0;
      if (nl == 3 && dsent == 0) begin
        kif.ap_done = 1'b1;
        dsent = 1;
      end
      tick();
    end
    kif.ap_done = 1'b0;
    kif.ap_ready = 1'b0;
    kif.last_V_ap_ack = 1'b1;
    checks++; if (nl !== 3) begin failures++; $display("FAIL skew_words got=%0d exp=3", nl); end
    checks++; if (err_val !== 0) begin failures++;
      $display("FAIL skew_data_stable got=%0d bad cycles exp=0", err_val); end
    checks++; if (err_vvld !== 0) begin failures++;
      $display("FAIL skew_value_vld got=%0d bad cycles exp=0", err_vvld); end
    checks++; if (ndn !== 1) begin failures++; $display("FAIL skew_ndone got=%0d exp=1", ndn); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL skew_busy_after got=%b exp=0", busy); end
  endtask

  task automatic test_early_done();
    issue_cmd(16'd2, 32'd7, 32'd3);
    run_stream(20, 2, 1, -1);
    checks++; if (nw !== 2 || got_val[0] !== 32'd7 || got_val[1] !== 32'd10) begin failures++;
      $display("FAIL early_words got n=%0d %0d,%0d exp n=2 7,10", nw, got_val[0], got_val[1]); end
    checks++; if (ndone !== 1) begin failures++; $display("FAIL early_ndone got=%0d exp=1", ndone); end
    checks++; if (done_iter !== 4) begin failures++;
      $display("FAIL early_done_time got=%0d exp=4", done_iter); end
  endtask

  task automatic test_wrap();
    issue_cmd(16'd3, 32'hFFFF_FFFE, 32'd1);
    run_stream(20, 3, -1, -1);
    checks++; if (got_val[0] !== 32'hFFFF_FFFE) begin failures++;
      $display("FAIL wrap_val0 got=%h exp=fffffffe", got_val[0]); end
    checks++; if (got_val[1] !== 32'hFFFF_FFFF) begin failures++;
      $display("FAIL wrap_val1 got=%h exp=ffffffff", got_val[1]); end
    checks++; if (got_val[2] !== 32'h0000_0000 || got_last[2] !== 1'b1) begin failures++;
      $display("FAIL wrap_val2 got=%h/%b exp=00000000/1", got_val[2], got_last[2]); end
    checks++; if (nw !== 3 || ndone !== 1) begin failures++;
      $display("FAIL wrap_counts got words=%0d done=%0d exp=3/1", nw, ndone); end
  endtask

  task automatic test_ignored();
    logic saw;
    issue_cmd(16'd0, 32'd5, 32'd1);
    saw = 1'b0;
    for (int c = 0; c < 6; c++) begin
      saw |= busy | done | kif.ap_start | kif.value_V_ap_vld | kif.last_V_ap_vld;
      tick();
    end
    checks++; if (saw !== 1'b0) begin failures++; $display("FAIL ign_len0 got activity=%b exp=0", saw); end

    kif.ap_idle = 1'b0;
    issue_cmd(16'd3, 32'd5, 32'd1);
    saw = 1'b0;
    for (int c = 0; c < 6; c++) begin
      saw |= busy | done | kif.ap_start | kif.value_V_ap_vld | kif.last_V_ap_vld;
      tick();
    end
    kif.ap_idle = 1'b1;
    checks++; if (saw !== 1'b0) begin failures++; $display("FAIL ign_not_idle got activity=%b exp=0", saw); end

    issue_cmd(16'd3, 32'd50, 32'd2);
    cfg_len  = 16'd5;
    cfg_base = 32'd999;
    run_stream(30, 3, -1, 2);
    checks++; if (nw !== 3) begin failures++; $display("FAIL ign_busy_words got=%0d exp=3", nw); end
    checks++; if (got_val[0] !== 32'd50 || got_val[1] !== 32'd52 || got_val[2] !== 32'd54) begin
      failures++;
      $display("FAIL ign_busy_vals got=%0d,%0d,%0d exp=50,52,54", got_val[0], got_val[1], got_val[2]);
    end
    checks++; if (ndone !== 1 || start_rises !== 1) begin failures++;
      $display("FAIL ign_busy_ctrl got done=%0d starts=%0d exp=1/1", ndone, start_rises); end

    issue_cmd(16'd1, 32'd77, 32'd0);
    cfg_len = 16'd2;
    run_stream(20, 1, -1, 2);
    checks++; if (done_iter !== 2 || nw !== 1) begin failures++;
      $display("FAIL ign_fin_timing got done_at=%0d words=%0d exp=2/1", done_iter, nw); end
    checks++; if (got_val[0] !== 32'd77 || got_last[0] !== 1'b1) begin failures++;
      $display("FAIL ign_single_word got=%0d/%b exp=77/1", got_val[0], got_last[0]); end
    checks++; if (busy !== 1'b0 || kif.ap_start !== 1'b0) begin failures++;
      $display("FAIL ign_fin_cmd got busy=%b ap_start=%b exp=0/0", busy, kif.ap_start); end
  endtask

  task automatic test_reset_mid();
    logic saw_done;
    issue_cmd(16'd5, 32'd200, 32'd3);
    kif.ap_ready = 1'b1;
    tick();
    tick();
    tick();
    checks++; if (busy !== 1'b1 || kif.value_V !== 32'd206) begin failures++;
      $display("FAIL rstmid_pre got busy=%b val=%0d exp=1/206", busy, kif.value_V); end
    rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0 || kif.ap_start !== 1'b0) begin failures++;
      $display("FAIL rstmid_ctrl got busy=%b done=%b start=%b exp=0/0/0", busy, done, kif.ap_start);
    end
    checks++; if ({kif.value_V_ap_vld, kif.last_V_ap_vld, kif.last_V} !== 3'b000
                  || kif.value_V !== 32'd0) begin failures++;
      $display("FAIL rstmid_stream got vld=%b%b last=%b val=%0d exp=000/0", kif.value_V_ap_vld,
               kif.last_V_ap_vld, kif.last_V, kif.value_V); end
    saw_done = 1'b0;
    for (int c = 0; c < 3; c++) begin
      saw_done |= done;
      tick();
    end
    kif.ap_ready = 1'b0;
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      saw_done |= done;
      tick();
    end
    checks++; if (saw_done !== 1'b0) begin failures++;
      $display("FAIL rstmid_no_done got=%b exp=0", saw_done); end
    issue_cmd(16'd2, 32'd300, 32'd1);
    run_stream(20, 2, -1, -1);
    checks++; if (nw !== 2 || got_val[0] !== 32'd300 || got_val[1] !== 32'd301) begin failures++;
      $display("FAIL rstmid_restart got n=%0d %0d,%0d exp n=2 300,301", nw, got_val[0], got_val[1]);
    end
    checks++; if (ndone !== 1) begin failures++; $display("FAIL rstmid_ndone got=%0d exp=1", ndone); end
  endtask

  initial begin
    kif.ap_ready       = 1'b0;
    kif.ap_done        = 1'b0;
    kif.ap_idle        = 1'b1;
    kif.value_V_ap_ack = 1'b1;
    kif.last_V_ap_ack  = 1'b1;
    test_reset();
    test_basic();
    test_skewed_acks();
    test_early_done();
    test_wrap();
    test_ignored();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/hs_stream_source.md
Name: hs_stream_source

Overview:
- Host-side driver for an HLS kernel that uses ap_ctrl_hs block control and ap_hs (vld/ack) scalar stream ports.
- It is the source end of the kernel's hw_input value/last stream pair.
- On command it raises ap_start, then streams N generated words (base + k*step) on separate value and last channels, each with its own vld/ack.
- It waits for the kernel's ap_done and then reports completion.
- It replaces hand-driven stimulus in kernel benches and in on-chip self-test.

Parameters:
- DATA_W, 32, width of the value channel.
- LEN_W, 16, width of the word-count configuration and internal counter.

Ports:
- ap_clk  in  1  single clock; all logic rising-edge.
- ap_rst_n  in  1  asynchronous, active-low reset.
- cfg_start  in  1  one-cycle command pulse; sampled only in IDLE.
- cfg_len  in  LEN_W  word count N, sampled with cfg_start.
- cfg_base  in  DATA_W  value of word 0, sampled with cfg_start.
- cfg_step  in  DATA_W  increment per word, sampled with cfg_start.
- busy  out  1  high from accepted command until done.
- done  out  1  one-cycle completion pulse.
- ap_start  out  1  kernel start, ap_ctrl_hs.
- ap_ready  in  1  kernel has accepted the start.
- ap_done  in  1  kernel finished (pulse).
- ap_idle  in  1  kernel idle; used only by the start guard.
- value_V  out  DATA_W  stream data.
- value_V_ap_vld  out  1  value channel valid.
- value_V_ap_ack  in  1  value channel accept.
- last_V  out  1  end-of-stream flag, 1 on word N-1.
- last_V_ap_vld  out  1  last channel valid.
- last_V_ap_ack  in  1  last channel accept.

Behaviour:
- Reset (async assert, sync release): all outputs 0; state IDLE; counters, latches and acked flags cleared. Reset mid-transfer aborts silently; no done pulse is produced.
- States: IDLE, RUN, DRAIN, FIN.
- IDLE -> RUN when cfg_start=1, cfg_len!=0 and ap_idle=1.
  - Latch len, base and step.
  - k=0; cur=base.
  - busy=1, ap_start=1 and both vld=1, all from the next cycle.
- IDLE, ignored commands: cfg_start with cfg_len=0 or ap_idle=0 is ignored (stays IDLE, no done). cfg_start outside IDLE is ignored.
- ap_start rule: held high until ap_ready is sampled high, then deasserted the following cycle. It is never re-raised within a command.
- Value/last channels:
  - value_V = cur; last_V = (k == len-1).
  - A channel transfers on a cycle with its vld=1 and ack=1. After transfer its vld drops and its acked flag sets.
  - Data on both channels is stable while either vld is high.
  - A word completes when both acked flags are set, or when the outstanding ack arrives this cycle. Acks may arrive in the same cycle or in different cycles, in either order.
- On word completion:
  - k+1; cur = cur + step, mod 2^DATA_W (wrap is legal).
  - Flags clear.
  - If k+1 < len, both vld re-assert on the next cycle. Minimum one cycle of vld=0 between words on each channel, so throughput is 1 word per 2 cycles.
  - If the completed word was the last one, go to DRAIN.
- ap_done latch: sticky done_seen. It is set by ap_done=1 in any RUN/DRAIN cycle, including before the last word completes.
- DRAIN -> FIN when done_seen=1, or ap_done=1 this cycle, and ap_start is already low. An ap_done before ap_ready is treated as a protocol error: the latch is still set, no special handling.
- FIN: done=1 for one cycle; busy=0 on the following cycle; -> IDLE. A cfg_start in FIN is ignored.
- Counter width: cfg_len max 2^LEN_W-1. k never exceeds len-1.

Decomposition:
- Package hs_stream_pkg: state enum, DATA_W/LEN_W defaults, localparam for IDLE encoding.
- One natural sub-module: hs_chan_tx. It holds one channel's vld/acked flag, with inputs load, ack, clear and outputs vld, acked. It is instantiated twice (value, last).

Test Plan:
- Basic: N=4, base=10, step=5, acks tied high, ap_ready one cycle after ap_start, ap_done after word 3 → values 10,15,20,25; last_V=1 only on 25; one done pulse; busy low after.
- Skewed acks: N=3; value ack immediate, last ack 3 cycles late for each word → value_V_ap_vld low while waiting; no word advance until last ack; 3 words total, data stable.
- Early ap_done: N=2; kernel pulses ap_done before word 1 acked → done pulses exactly one cycle after word 1 completes.
- Wrap: DATA_W=32, base=0xFFFFFFFE, step=1, N=3 → 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000.
- Ignored commands: cfg_len=0 → no ap_start, no done. cfg_start while busy → no effect on the in-flight stream. ap_idle=0 at command → ignored.
- Reset mid-stream: assert ap_rst_n=0 after word 1 of N=5 → all outputs 0 immediately, no done. A new command after release starts from base.
